// File: rtl/serial_link_pkg.sv
// -----------------------------------------------------------------------------
// serial_link_pkg
// Shared types and constants for the enable-qualified serial link.
//   tx_state_e        : transmitter FSM states
//   SERIAL_DATA_W     : default payload width
//   SERIAL_GAP_CYCLES : en=0 cycles inserted after each frame
// -----------------------------------------------------------------------------
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    GAP    = 2'd2,
    PARITY = 2'd3
  } tx_state_e;

  localparam int unsigned SERIAL_DATA_W     = 8;
  localparam int unsigned SERIAL_GAP_CYCLES = 1;

endpackage

// File: rtl/serial_frame_tx_piso_shreg.sv
// -----------------------------------------------------------------------------
// piso_shreg
// Parallel-load, shift-right register with LSB output.
//   clk, rst   : clock, asynchronous active-high reset (clears contents)
//   load       : capture load_data (has priority over shift)
//   shift      : shift right by one, zero fill at the MSB
//   load_data  : parallel word
//   lsb        : current bit 0
// -----------------------------------------------------------------------------
module piso_shreg
  import serial_link_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             lsb
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= load_data;
    end else if (shift) begin
      sr_q <= {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  assign lsb = sr_q[0];

endmodule

// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
// Bit-serial frame transmitter. Accepts a DATA_W-bit word on a valid/ready
// handshake and sends it LSB-first on d, each bit qualified by en. Every frame
// is followed by a one-cycle en=0 gap carrying the frame_done pulse.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   tx_data     : word to send, sampled only on the accept edge
//   tx_valid    : producer has a word
//   tx_ready    : transmitter idle and able to accept
//   d           : serial data bit (registered)
//   en          : bit-valid strobe (registered)
//   busy        : frame in progress (SHIFT, PARITY or GAP)
//   frame_done  : one-cycle pulse during the gap after a frame
//
// Build option:
//   SERIAL_FRAME_TX_PARITY_EN : when defined, an even-parity bit is appended
//                               as one extra strobed bit after the data.
// -----------------------------------------------------------------------------
module serial_frame_tx
  import serial_link_pkg::*;
#(
  parameter int unsigned DATA_W = SERIAL_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              d,
  output logic              en,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned     CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(SERIAL_GAP_CYCLES - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_q, d_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             sr_load, sr_shift, sr_lsb;
  logic [DATA_W-1:0] sr_load_data;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // Bit 0 goes straight into the d register on the accept edge, so the shift
  // register is loaded one position ahead: during data bit k it holds
  // word >> (k+1) and its LSB is the next bit to drive.
  assign sr_load_data = {1'b0, tx_data[DATA_W-1:1]};

  piso_shreg #(
    .WIDTH (DATA_W)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (sr_load),
    .shift     (sr_shift),
    .load_data (sr_load_data),
    .lsb       (sr_lsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      en_q    <= en_d;
      done_q  <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic computes the values d/en/frame_done take in the *next*
  // cycle, so the registered outputs line up with the state they belong to.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    d_d      = 1'b0;
    en_d     = 1'b0;
    done_d   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    par_d    = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sr_load = 1'b1;
          d_d     = tx_data[0];
          en_d    = 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end

      SHIFT: begin
        sr_shift = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          state_d = PARITY;
          d_d     = par_q;
          en_d    = 1'b1;
`else
          state_d = GAP;
          cnt_d   = '0;
          done_d  = 1'b1;
`endif
        end else begin
          d_d  = sr_lsb;
          en_d = 1'b1;
        end
      end

`ifdef SERIAL_FRAME_TX_PARITY_EN
      PARITY: begin
        state_d = GAP;
        cnt_d   = '0;
        done_d  = 1'b1;
      end
`endif

      GAP: begin
        if (cnt_q == LAST_GAP) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign d          = d_q;
  assign en         = en_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
`timescale 1ns/1ps
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned NBITS    = 8 + PAR;   // strobed bits per 8-bit frame
  localparam int unsigned PERIOD   = 10 + PAR;  // accept-to-accept spacing
  localparam int unsigned N_NBITS  = 2 + PAR;
  localparam int unsigned N_PERIOD = 4 + PAR;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, d, en, busy, frame_done;

  logic [1:0] n_data;
  logic       n_valid;
  logic       n_ready, n_d, n_en, n_busy, n_done;

  logic [4:0] st, n_st;
  assign st   = {tx_ready, busy, en, d, frame_done};
  assign n_st = {n_ready, n_busy, n_en, n_d, n_done};

  int checks = 0;
  int errors = 0;

  serial_frame_tx dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .d          (d),
    .en         (en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  serial_frame_tx #(.DATA_W(2)) dut_n (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (n_data),
    .tx_valid   (n_valid),
    .tx_ready   (n_ready),
    .d          (n_d),
    .en         (n_en),
    .busy       (n_busy),
    .frame_done (n_done)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected k-th strobed bit of an 8-bit frame (bit 8 is even parity).
  function automatic logic exp_bit(input logic [7:0] w, input int unsigned k);
    if (k < 8) return w[3'(k)];
    return ^w;
  endfunction

  function automatic logic exp_bit2(input logic [1:0] w, input int unsigned k);
    if (k < 2) return w[1'(k)];
    return ^w;
  endfunction

  // status vector: {tx_ready, busy, en, d, frame_done}
  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; n_valid = 1'b0; n_data = '0;
    step();
    checks++;
    if (st !== 5'b10000) begin
      errors++; $display("FAIL reset_state: got %b expected %b", st, 5'b10000);
    end
    checks++;
    if (n_st !== 5'b10000) begin
      errors++; $display("FAIL reset_state_narrow: got %b expected %b", n_st, 5'b10000);
    end
    rst = 1'b0;
    step();
    checks++;
    if (st !== 5'b10000) begin
      errors++; $display("FAIL post_reset_idle: got %b expected %b", st, 5'b10000);
    end
  endtask

  task automatic test_single();
    logic [7:0] w = 8'hA5;
    tx_data = w; tx_valid = 1'b1;
    step();                        // accept edge passed; cycle accept+1
    tx_valid = 1'b0;
    for (int k = 0; k < int'(NBITS); k++) begin
      checks++;
      if (st !== {1'b0, 1'b1, 1'b1, exp_bit(w, k), 1'b0}) begin
        errors++;
        $display("FAIL single_bit%0d: got %b expected %b", k, st,
                 {1'b0, 1'b1, 1'b1, exp_bit(w, k), 1'b0});
      end
      step();
    end
    checks++;
    if (st !== 5'b01001) begin
      errors++; $display("FAIL single_gap: got %b expected %b", st, 5'b01001);
    end
    step();
    checks++;
    if (st !== 5'b10000) begin
      errors++; $display("FAIL single_idle: got %b expected %b", st, 5'b10000);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    logic [7:0] w;
    int unsigned p;
    tx_data = 8'h01; tx_valid = 1'b1;
    step();
    tx_data = 8'h80;               // only captured on the second accept edge
    for (int j = 1; j <= int'(2 * PERIOD); j++) begin
      p = (j - 1) % PERIOD;
      w = (j <= int'(PERIOD)) ? 8'h01 : 8'h80;
      if (p < NBITS)       exp = {1'b0, 1'b1, 1'b1, exp_bit(w, p), 1'b0};
      else if (p == NBITS) exp = 5'b01001;
      else                 exp = 5'b10000;
      checks++;
      if (st !== exp) begin
        errors++; $display("FAIL b2b_cycle%0d: got %b expected %b", j, st, exp);
      end
      if (j == int'(PERIOD) + 1) tx_valid = 1'b0;
      step();
    end
    checks++;
    if (st !== 5'b10000) begin
      errors++; $display("FAIL b2b_no_third: got %b expected %b", st, 5'b10000);
    end
  endtask

  task automatic test_ignore_midframe();
    logic [7:0] w = 8'h3C;
    tx_data = w; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int k = 0; k < int'(NBITS); k++) begin
      if (k == 3) begin tx_data = 8'hFF; tx_valid = 1'b1; end
      if (k == 4) tx_valid = 1'b0;
      checks++;
      if (st !== {1'b0, 1'b1, 1'b1, exp_bit(w, k), 1'b0}) begin
        errors++;
        $display("FAIL ignore_bit%0d: got %b expected %b", k, st,
                 {1'b0, 1'b1, 1'b1, exp_bit(w, k), 1'b0});
      end
      step();
    end
    checks++;
    if (st !== 5'b01001) begin
      errors++; $display("FAIL ignore_gap: got %b expected %b", st, 5'b01001);
    end
    for (int j = 0; j < 4; j++) begin
      step();
      checks++;
      if (st !== 5'b10000) begin
        errors++; $display("FAIL ignore_no_frame%0d: got %b expected %b", j, st, 5'b10000);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] w = 8'hF0;
    logic [7:0] w2 = 8'h0F;
    tx_data = w; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (st !== {1'b0, 1'b1, 1'b1, w[3], 1'b0}) begin
      errors++; $display("FAIL rstmid_bit3: got %b expected %b", st, {1'b0, 1'b1, 1'b1, w[3], 1'b0});
    end
    #2 rst = 1'b1;
    #1;                            // no clock edge since rst rose
    checks++;
    if (st !== 5'b10000) begin
      errors++; $display("FAIL rstmid_async_clear: got %b expected %b", st, 5'b10000);
    end
    step();
    #2 rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      step();
      checks++;
      if (st !== 5'b10000) begin
        errors++; $display("FAIL rstmid_quiet%0d: got %b expected %b", j, st, 5'b10000);
      end
    end
    tx_data = w2; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int k = 0; k < int'(NBITS); k++) begin
      checks++;
      if (st !== {1'b0, 1'b1, 1'b1, exp_bit(w2, k), 1'b0}) begin
        errors++;
        $display("FAIL rstmid_new_bit%0d: got %b expected %b", k, st,
                 {1'b0, 1'b1, 1'b1, exp_bit(w2, k), 1'b0});
      end
      step();
    end
    checks++;
    if (st !== 5'b01001) begin
      errors++; $display("FAIL rstmid_new_gap: got %b expected %b", st, 5'b01001);
    end
    step();
  endtask

`ifdef SERIAL_FRAME_TX_PARITY_EN
  task automatic test_parity();
    tx_data = 8'h07; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (st !== 5'b01110) begin
      errors++; $display("FAIL parity_bit_07: got %b expected %b", st, 5'b01110);
    end
    step();
    checks++;
    if (st !== 5'b01001) begin
      errors++; $display("FAIL parity_done_07: got %b expected %b", st, 5'b01001);
    end
    step();
  endtask
`endif

  task automatic test_narrow();
    logic [1:0] w = 2'b10;
    logic [4:0] exp;
    int unsigned p;
    n_data = w; n_valid = 1'b1;
    step();
    for (int j = 1; j <= int'(2 * N_PERIOD); j++) begin
      p = (j - 1) % N_PERIOD;
      if (p < N_NBITS)       exp = {1'b0, 1'b1, 1'b1, exp_bit2(w, p), 1'b0};
      else if (p == N_NBITS) exp = 5'b01001;
      else                   exp = 5'b10000;
      checks++;
      if (n_st !== exp) begin
        errors++; $display("FAIL narrow_cycle%0d: got %b expected %b", j, n_st, exp);
      end
      if (j == int'(2 * N_PERIOD)) n_valid = 1'b0;
      step();
    end
    checks++;
    if (n_st !== 5'b10000) begin
      errors++; $display("FAIL narrow_idle: got %b expected %b", n_st, 5'b10000);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
`ifdef SERIAL_FRAME_TX_PARITY_EN
    test_parity();
`endif
    test_narrow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
